// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the EX-stage HI/LO sequencer: opcodes and FSM states.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier and iterative divider; owns HI/LO.
// The divider handshake is start/ready: div_start stays high with stable operands
// until div_ready is seen, and div_annul pulses for one cycle to abandon a divide.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output state_t      dbg_state
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic               r_signed;

    logic               w_take;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_issue;

    // Gated by resetn so every output reads 0 while reset is asserted.
    assign w_take   = resetn && op_valid && !flush && (r_state == ST_IDLE);
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign w_is_div = ((op == OP_DIV) || (op == OP_DIVU)) && (src_b != 32'd0);
    assign w_issue  = w_take && (w_is_mul || w_is_div);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_signed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        if (w_is_mul) begin
                            r_opa    <= src_a;
                            r_opb    <= src_b;
                            r_signed <= (op == OP_MULT);
                            r_cnt    <= CNT_W'(MUL_LAT - 1);
                            r_state  <= ST_MUL_BUSY;
                        end else if (w_is_div) begin
                            r_opa    <= src_a;
                            r_opb    <= src_b;
                            r_signed <= (op == OP_DIV);
                            r_state  <= ST_DIV_BUSY;
                        end else if (op == OP_MTHI) begin
                            r_hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= src_a;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        {r_hi, r_lo} <= mul_result;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV_BUSY: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (div_ready) begin
                        {r_hi, r_lo} <= div_result;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // op_valid still shows the finished instruction; wait for EX to move.
                    if (flush || !ex_hold) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stallreq   = w_issue || (r_state == ST_MUL_BUSY) || (r_state == ST_DIV_BUSY);
    assign busy       = (r_state != ST_IDLE);
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign mul_signed = r_signed;
    assign mul_ina    = r_opa;
    assign mul_inb    = r_opb;
    assign div_signed = r_signed;
    assign div_opa    = r_opa;
    assign div_opb    = r_opb;
    assign div_start  = (r_state == ST_DIV_BUSY) && !div_ready && !flush;
    assign div_annul  = (r_state == ST_DIV_BUSY) && flush;
    assign dbg_state  = r_state;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- EX-stage sequencer for the shared multiplier (`mul`) and iterative divider (`div`).
- Accepts one HI/LO-class op per EX instruction, holds the operands stable, drives the unit handshakes and raises the EX stall request until the result is ready.
- Owns the architectural HI/LO registers, including MTHI/MTLO writes and flush/annul.

Parameters:
- MUL_LAT, 2: cycles from operands presented to the `mul` inputs until `mul_result` is valid. Legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- op_valid  in  1  EX holds a valid instruction
- op  in  3  muldiv opcode (package encoding)
- src_a  in  32  rs value
- src_b  in  32  rt value
- ex_hold  in  1  EX register is frozen by a stall from another stage
- flush  in  1  kill the in-flight op
- stallreq  out  1  request to stall IF..EX
- busy  out  1  state != IDLE
- hi  out  32  HI register
- lo  out  32  LO register
- mul_signed  out  1  to `mul`
- mul_ina, mul_inb  out  32 each  registered operands to `mul`
- mul_result  in  64  {HI, LO} product
- div_start  out  1  to `div` start_i
- div_signed  out  1  to `div`
- div_opa, div_opb  out  32 each  registered dividend and divisor
- div_annul  out  1  to `div` annul_i
- div_ready  in  1  `div` ready_o
- div_result  in  64  {remainder, quotient}

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE, hi=lo=0, operand regs=0.
  - All outputs are 0.
- IDLE state:
  - MULT/MULTU issue: when op_valid && !flush, latch src_a/src_b and the signedness, load cnt=MUL_LAT-1, go to MUL_BUSY. stallreq=1 combinationally in the issue cycle.
  - DIV/DIVU with src_b!=0: latch operands and signedness, go to DIV_BUSY. stallreq=1.
  - DIV/DIVU with src_b==0: no issue, no stall, HI/LO unchanged, remain in IDLE.
  - MTHI/MTLO: hi (or lo) <= src_a at the clock edge. No stall, remain in IDLE.
- MUL_BUSY state:
  - mul_ina/mul_inb/mul_signed are driven from the registered operands. stallreq=1.
  - cnt decrements each cycle.
  - At the edge where cnt==0: {hi,lo} <= mul_result, go to DONE.
  - Total stall = MUL_LAT+1 cycles.
- DIV_BUSY state:
  - div_start=1 with the registered operands. stallreq=1.
  - When div_ready=1: {hi,lo} <= div_result, i.e. hi=remainder, lo=quotient. div_start=0 in that cycle. Go to DONE.
- DONE state:
  - stallreq=0, so the pipeline advances past the finished instruction.
  - op_valid is ignored here, because it still shows the same instruction.
  - Return to IDLE when ex_hold=0. Remain in DONE while ex_hold=1, so a frozen EX never reissues.
- flush:
  - In any BUSY or DONE state: go to IDLE next edge, no HI/LO write.
  - From DIV_BUSY: div_annul=1 and div_start=0 in the flush cycle.
  - In IDLE, flush takes priority over op_valid and MTHI/MTLO.
- Ops outside IDLE: MTHI/MTLO and any op arriving outside IDLE are ignored.
- NOP or unused encodings: no action.
- Outputs:
  - busy = (state != IDLE).
  - hi and lo are register outputs with no bypass; a write is visible the cycle after its edge.
- Reset mid-operation: aborts immediately to IDLE. The divider is reset by the same resetn.

Decomposition:
- Shared package/defines (next to `defines.vh`):
  - Opcode encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - State encoding: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- No sub-module: the FSM, counter and HI/LO registers live in one module. `mul` and `div` are instantiated by EX, not inside this block.

Test Plan:
- Signed MULT, MUL_LAT=2: MULT a=0xFFFFFFFE, b=3 → stallreq high exactly 3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, 1 DONE cycle, back to IDLE.
- Unsigned MULTU: same operands → hi=0x00000002, lo=0xFFFFFFFA, mul_signed=0 throughout.
- DIVU with a behavioural divider (ready after 33 cycles): 100/7 → hi=2, lo=14. Signed DIV -7/2 (0xFFFFFFF9/2) → hi=0xFFFFFFFF, lo=0xFFFFFFFD. Check div_start stays high until ready.
- Divide by zero, then MTHI/MTLO: DIV 5/0 → no stall, hi/lo unchanged. MTHI 0x12345678 then MTLO 0x9ABCDEF0 → each takes effect the next cycle with no stall.
- Flush mid-divide: flush 10 cycles into a DIV → div_annul pulses 1 cycle, HI/LO keep their old values, state=IDLE. A following MULT issues normally.
- ex_hold in DONE: hold ex_hold=1 for 4 cycles after a MULT completes with op_valid still high → exactly one HI/LO write, no reissue, stallreq=0. Async resetn pulse in MUL_BUSY → all outputs 0 immediately.
